// File: rtl/adder_word_seq.sv
// Multi-precision add/subtract sequencer: one 32-bit adder shared across
// N words, LSW first, with the carry chained through a register.

module adder_word (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        carry_in,
    output logic [31:0] sum,
    output logic        carry_out
);

    assign {carry_out, sum} = {1'b0, a} + {1'b0, b} + {32'b0, carry_in};

endmodule

module adder_word_seq #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [CNT_W-1:0] n_words,
    output logic             busy,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      a_word,
    input  logic [31:0]      b_word,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      sum_word,
    output logic             out_last,
    output logic             carry_out,
    output logic             overflow,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    state_t           state, state_nx;
    logic             sub_q, sub_nx;
    logic [CNT_W-1:0] n_q, n_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             carry_q, carry_nx;
    logic [31:0]      sum_nx;
    logic             valid_nx, last_nx, cout_nx, ovf_nx, done_nx;

    logic [31:0] b_eff;
    logic [31:0] add_sum;
    logic        add_co;
    logic        add_ovf;
    logic        is_last;
    logic        in_fire;
    logic        out_fire;

    // Subtraction is A + ~B + 1; the +1 comes from seeding the carry with sub.
    assign b_eff = sub_q ? ~b_word : b_word;

    adder_word u_adder (
        .a         (a_word),
        .b         (b_eff),
        .carry_in  (carry_q),
        .sum       (add_sum),
        .carry_out (add_co)
    );

    assign add_ovf  = (a_word[31] == b_eff[31]) && (add_sum[31] != a_word[31]);
    assign is_last  = (cnt == n_q - CNT_W'(1));
    assign busy     = (state != IDLE);
    assign in_ready = (state == RUN) && (!out_valid || out_ready);
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            sub_q     <= 1'b0;
            n_q       <= '0;
            cnt       <= '0;
            carry_q   <= 1'b0;
            sum_word  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nx;
            sub_q     <= sub_nx;
            n_q       <= n_nx;
            cnt       <= cnt_nx;
            carry_q   <= carry_nx;
            sum_word  <= sum_nx;
            out_valid <= valid_nx;
            out_last  <= last_nx;
            carry_out <= cout_nx;
            overflow  <= ovf_nx;
            done      <= done_nx;
        end
    end

    always_comb begin
        state_nx = state;
        sub_nx   = sub_q;
        n_nx     = n_q;
        cnt_nx   = cnt;
        carry_nx = carry_q;
        sum_nx   = sum_word;
        valid_nx = out_valid;
        last_nx  = out_last;
        cout_nx  = carry_out;
        ovf_nx   = overflow;
        done_nx  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start && (n_words != '0)) begin
                    sub_nx   = sub;
                    n_nx     = n_words;
                    carry_nx = sub;
                    cnt_nx   = '0;
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (in_fire) begin
                    sum_nx   = add_sum;
                    valid_nx = 1'b1;
                    carry_nx = add_co;
                    cnt_nx   = cnt + CNT_W'(1);
                    last_nx  = is_last;
                    cout_nx  = is_last & add_co;
                    ovf_nx   = is_last & add_ovf;
                    if (is_last) begin
                        state_nx = DRAIN;
                    end
                end else if (out_fire) begin
                    valid_nx = 1'b0;
                end
            end
            DRAIN: begin
                if (out_fire) begin
                    done_nx  = 1'b1;
                    valid_nx = 1'b0;
                    last_nx  = 1'b0;
                    cout_nx  = 1'b0;
                    ovf_nx   = 1'b0;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule
